// File: rtl/dip_switch_debouncer.sv
// dip_switch_debouncer
//
// Conditions the two raw DIP-switch operand banks before they reach the display
// multiplexer and the adder. Each bank goes through a 2-flop synchroniser and is
// then debounced: a synchronised value must hold for DB_CYCLES consecutive clocks
// before it is accepted. Both banks are independent and identical.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset (clears every register)
//   s1_raw      raw switch bank 1 (asynchronous)
//   s2_raw      raw switch bank 2 (asynchronous)
//   s1, s2      debounced bank values (pure register outputs)
//   s1_changed  one-cycle pulse when s1 takes a new value
//   s2_changed  one-cycle pulse when s2 takes a new value

module dip_switch_debouncer #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned DB_CYCLES = 240000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s1_raw,
    input  logic [WIDTH-1:0] s2_raw,
    output logic [WIDTH-1:0] s1,
    output logic [WIDTH-1:0] s2,
    output logic             s1_changed,
    output logic             s2_changed
);

    localparam int unsigned NumCh = 2;
    localparam int unsigned CntW  = $clog2(DB_CYCLES);
    localparam logic [CntW-1:0] CntMax = CntW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] raw [NumCh];

    logic [WIDTH-1:0] sync1_q  [NumCh];
    logic [WIDTH-1:0] sync2_q  [NumCh];
    logic [WIDTH-1:0] cand_q   [NumCh];
    logic [WIDTH-1:0] cand_d   [NumCh];
    logic [WIDTH-1:0] stable_q [NumCh];
    logic [WIDTH-1:0] stable_d [NumCh];
    logic [CntW-1:0]  cnt_q    [NumCh];
    logic [CntW-1:0]  cnt_d    [NumCh];
    logic             changed_q[NumCh];
    logic             changed_d[NumCh];

    assign raw[0] = s1_raw;
    assign raw[1] = s2_raw;

    always_comb begin
        for (int c = 0; c < NumCh; c++) begin
            cand_d[c]    = cand_q[c];
            cnt_d[c]     = cnt_q[c];
            stable_d[c]  = stable_q[c];
            changed_d[c] = 1'b0;
            if (sync2_q[c] != cand_q[c]) begin
                // Any disagreement, including a return to the old value, restarts the count.
                cand_d[c] = sync2_q[c];
                cnt_d[c]  = '0;
            end else if (cnt_q[c] < CntMax) begin
                cnt_d[c] = cnt_q[c] + CntW'(1);
            end else if (cand_q[c] != stable_q[c]) begin
                // Counter saturates here; only a genuinely new value produces a pulse.
                stable_d[c]  = cand_q[c];
                changed_d[c] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NumCh; c++) begin
                sync1_q[c]   <= '0;
                sync2_q[c]   <= '0;
                cand_q[c]    <= '0;
                cnt_q[c]     <= '0;
                stable_q[c]  <= '0;
                changed_q[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < NumCh; c++) begin
                sync1_q[c]   <= raw[c];
                sync2_q[c]   <= sync1_q[c];
                cand_q[c]    <= cand_d[c];
                cnt_q[c]     <= cnt_d[c];
                stable_q[c]  <= stable_d[c];
                changed_q[c] <= changed_d[c];
            end
        end
    end

    assign s1         = stable_q[0];
    assign s2         = stable_q[1];
    assign s1_changed = changed_q[0];
    assign s2_changed = changed_q[1];

endmodule

// File: tb/tb_dip_switch_debouncer.sv
// Scoreboard bench for dip_switch_debouncer. Main instance uses DB_CYCLES=4,
// a second instance uses DB_CYCLES=2. Stimulus pushes (channel, value, cycle)
// expectations; a negedge monitor pops one entry per observed changed pulse.
// Channels: 0 = dut_a.s1, 1 = dut_a.s2, 2 = dut_b.s1, 3 = dut_b.s2.

module tb_dip_switch_debouncer;

    localparam int DbA = 4;
    localparam int DbB = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] s1_raw, s2_raw, b_s1_raw, b_s2_raw;
    logic [3:0] s1, s2, b_s1, b_s2;
    logic       s1_changed, s2_changed, b_s1_changed, b_s2_changed;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int ch;
        int val;
        int cyc;
    } exp_t;

    exp_t sb_q[$];

    dip_switch_debouncer #(.WIDTH(4), .DB_CYCLES(DbA)) dut_a (
        .clk        (clk),
        .reset      (reset),
        .s1_raw     (s1_raw),
        .s2_raw     (s2_raw),
        .s1         (s1),
        .s2         (s2),
        .s1_changed (s1_changed),
        .s2_changed (s2_changed)
    );

    dip_switch_debouncer #(.WIDTH(4), .DB_CYCLES(DbB)) dut_b (
        .clk        (clk),
        .reset      (reset),
        .s1_raw     (b_s1_raw),
        .s2_raw     (b_s2_raw),
        .s1         (b_s1),
        .s2         (b_s2),
        .s1_changed (b_s1_changed),
        .s2_changed (b_s2_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every changed pulse must match the oldest pending entry of its channel.
    always @(negedge clk) begin
        logic [3:0] v [4];
        logic       p [4];
        int         idx;
        v[0] = s1;   v[1] = s2;   v[2] = b_s1;   v[3] = b_s2;
        p[0] = s1_changed;   p[1] = s2_changed;
        p[2] = b_s1_changed; p[3] = b_s2_changed;
        for (int c = 0; c < 4; c++) begin
            if (p[c] !== 1'b0) begin
                idx = -1;
                for (int i = 0; i < sb_q.size(); i++) begin
                    if (idx < 0 && sb_q[i].ch == c) idx = i;
                end
                checks++;
                if (idx < 0) begin
                    errors++;
                    $display("FAIL pulse_ch%0d: got pulse (value %0d) at cycle %0d, required no pulse",
                             c, v[c], cyc);
                end else begin
                    if (int'(v[c]) != sb_q[idx].val || cyc != sb_q[idx].cyc) begin
                        errors++;
                        $display("FAIL pulse_ch%0d: got value %0d at cycle %0d, required value %0d at cycle %0d",
                                 c, v[c], cyc, sb_q[idx].val, sb_q[idx].cyc);
                    end
                    sb_q.delete(idx);
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Called at a negedge right after the stimulus change (or reset release).
    task automatic expect_pulse(input int ch, input int val, input int db);
        exp_t e;
        e.ch  = ch;
        e.val = val;
        e.cyc = cyc + db + 3;
        sb_q.push_back(e);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulses outstanding, required 0", name, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        s1_raw   = 4'd4;
        s2_raw   = 4'd5;
        b_s1_raw = 4'd0;
        b_s2_raw = 4'd0;

        // 1. Reset held for 3 cycles, then steady 4/5.
        idle(3);
        check("reset_s1", int'(s1), 0);
        check("reset_s2", int'(s2), 0);
        check("reset_s1_changed", int'(s1_changed), 0);
        check("reset_s2_changed", int'(s2_changed), 0);
        check("reset_b_s1", int'(b_s1), 0);
        reset = 1'b0;
        expect_pulse(0, 4, DbA);
        expect_pulse(1, 5, DbA);
        drain("t1_drain", 20);
        check("t1_s1", int'(s1), 4);
        check("t1_s2", int'(s2), 5);

        // 2. Clean change on s1 only.
        s1_raw = 4'd8;
        expect_pulse(0, 8, DbA);
        drain("t2_drain", 20);
        check("t2_s1", int'(s1), 8);
        check("t2_s2", int'(s2), 5);

        // 3. Bounce 8,1,8,1,8,1 then settle at 1.
        for (int i = 0; i < 6; i++) begin
            s1_raw = (i % 2 == 0) ? 4'd8 : 4'd1;
            if (i == 5) expect_pulse(0, 1, DbA);
            @(negedge clk);
        end
        check("t3_s1_during", int'(s1), 8);
        drain("t3_drain", 20);
        check("t3_s1", int'(s1), 1);

        // 4. Two-cycle glitch to 15, back to 1: no update, no pulse.
        s1_raw = 4'd15;
        idle(2);
        s1_raw = 4'd1;
        idle(12);
        check("t4_s1", int'(s1), 1);
        check("t4_sb_empty", sb_q.size(), 0);

        // 5. Simultaneous change on both channels, DB=4 and DB=2 instances.
        s1_raw = 4'd0;
        s2_raw = 4'd0;
        expect_pulse(0, 0, DbA);
        expect_pulse(1, 0, DbA);
        drain("t5_zero_drain", 20);
        s1_raw   = 4'd15;
        s2_raw   = 4'd15;
        b_s1_raw = 4'd15;
        b_s2_raw = 4'd15;
        expect_pulse(0, 15, DbA);
        expect_pulse(1, 15, DbA);
        expect_pulse(2, 15, DbB);
        expect_pulse(3, 15, DbB);
        drain("t5_drain", 20);
        check("t5_s1", int'(s1), 15);
        check("t5_s2", int'(s2), 15);
        check("t5_b_s1", int'(b_s1), 15);
        check("t5_b_s2", int'(b_s2), 15);

        // 6. Reset in the middle of a pending s2 change.
        s2_raw = 4'd5;
        expect_pulse(1, 5, DbA);
        drain("t6_pre_drain", 20);
        s2_raw = 4'd13;
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("t6_async_s2", int'(s2), 0);
        check("t6_async_s1", int'(s1), 0);
        check("t6_async_b_s2", int'(b_s2), 0);
        idle(2);
        reset = 1'b0;
        expect_pulse(0, 15, DbA);
        expect_pulse(1, 13, DbA);
        expect_pulse(2, 15, DbB);
        expect_pulse(3, 15, DbB);
        drain("t6_drain", 20);
        check("t6_s2", int'(s2), 13);
        check("t6_s1", int'(s1), 15);

        idle(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
